// File: rtl/loader_pkg.sv
// Shared types for the program loader: FSM state encoding and byte width.
package loader_pkg;
    localparam int BYTE_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        RECV,
        WRITE,
        FINISH
    } loader_state_t;
endpackage

// File: rtl/word_assembler.sv
// Big-endian byte-to-word shift register with a byte counter.
module word_assembler
    import loader_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  shift_i,
    input  logic                  clear_i,
    input  logic [7:0]            byte_i,
    output logic [DATA_WIDTH-1:0] word_o,
    output logic                  word_full_o
);
    localparam int WORD_BYTES = DATA_WIDTH / BYTE_WIDTH;
    localparam int CNT_W      = $clog2(WORD_BYTES + 1);

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;

    // Asserted on the shift that brings in the last byte of a word.
    assign word_full_o = shift_i && (cnt_q == CNT_W'(WORD_BYTES - 1));
    assign word_o      = word_q;

    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (shift_i) begin
            word_d = (word_q << BYTE_WIDTH) | DATA_WIDTH'(byte_i);
            cnt_d  = word_full_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            word_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
        end
    end
endmodule

// File: rtl/program_loader.sv
// Shares the program RAM port between instruction fetch and a byte-serial
// program download that writes consecutive words from address 0.
module program_loader
    import loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_req,
    input  logic [ADDR_WIDTH-1:0] load_len,
    input  logic                  abort,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    input  logic [ADDR_WIDTH-1:0] fetch_address,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_write,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted
);
    loader_state_t         state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [ADDR_WIDTH-1:0] rem_q, rem_d;
    logic                  aborted_q, aborted_d;
    logic                  asm_clear;
    logic                  asm_full;

    word_assembler #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_asm (
        .clk        (clk),
        .rst_n      (reset),
        .shift_i    (byte_valid && byte_ready),
        .clear_i    (asm_clear),
        .byte_i     (byte_data),
        .word_o     (mem_data),
        .word_full_o(asm_full)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        rem_d       = rem_q;
        aborted_d   = aborted_q;
        asm_clear   = 1'b0;
        byte_ready  = 1'b0;
        mem_write   = 1'b0;
        cpu_hold    = 1'b1;
        busy        = 1'b1;
        done        = 1'b0;
        aborted     = 1'b0;
        mem_address = ptr_q;

        unique case (state_q)
            IDLE: begin
                cpu_hold    = 1'b0;
                busy        = 1'b0;
                mem_address = fetch_address;
                // A simultaneous abort is irrelevant here: the load wins.
                if (load_req) begin
                    rem_d     = load_len;
                    ptr_d     = '0;
                    aborted_d = 1'b0;
                    asm_clear = 1'b1;
                    state_d   = ARM;
                end
            end
            ARM: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = FINISH;
                end else if (rem_q == '0) begin
                    state_d = FINISH;
                end else begin
                    state_d = RECV;
                end
            end
            RECV: begin
                byte_ready = 1'b1;
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = FINISH;
                end else if (asm_full) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                // The write is issued even when abort arrives in this cycle.
                mem_write = 1'b1;
                ptr_d     = ptr_q + 1'b1;
                rem_d     = rem_q - 1'b1;
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = FINISH;
                end else if (rem_q == ADDR_WIDTH'(1)) begin
                    state_d = FINISH;
                end else begin
                    state_d = RECV;
                end
            end
            FINISH: begin
                done    = 1'b1;
                aborted = aborted_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            rem_q     <= '0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            rem_q     <= rem_d;
            aborted_q <= aborted_d;
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader with a word-level write model.
module tb_program_loader;
    localparam int AW = 12;
    localparam int DW = 16;
    localparam int WB = DW / 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          load_req = 1'b0;
    logic [AW-1:0] load_len = '0;
    logic          abort = 1'b0;
    logic          byte_valid = 1'b0;
    logic [7:0]    byte_data = '0;
    logic          byte_ready;
    logic [AW-1:0] fetch_address = '0;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data;
    logic          mem_write;
    logic          cpu_hold;
    logic          busy;
    logic          done;
    logic          aborted;

    program_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .reset        (reset),
        .load_req     (load_req),
        .load_len     (load_len),
        .abort        (abort),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_ready   (byte_ready),
        .fetch_address(fetch_address),
        .mem_address  (mem_address),
        .mem_data     (mem_data),
        .mem_write    (mem_write),
        .cpu_hold     (cpu_hold),
        .busy         (busy),
        .done         (done),
        .aborted      (aborted)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model: expected RAM writes {address, word}, built from the bytes sent.
    logic [AW+DW-1:0] exp_q[$];
    int               m_ptr;
    int               m_nbytes;
    logic [DW-1:0]    m_word;
    bit               m_active = 1'b0;

    // Observations gathered by the compare process.
    bit            done_seen;
    int            done_cyc;
    logic          done_abt;
    int            hold_cnt;
    int            wr_cnt;
    logic [AW-1:0] last_wr_addr;
    logic [DW-1:0] last_wr_data;
    int            req_cyc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (cpu_hold) hold_cnt++;
            if (mem_write) begin
                wr_cnt++;
                last_wr_addr = mem_address;
                last_wr_data = mem_data;
            end
            if (!m_active) begin
                chk("idle_addr", mem_address, fetch_address);
                chk("idle_write", mem_write, 0);
                chk("idle_ready", byte_ready, 0);
                chk("idle_busy", busy, 0);
                chk("idle_hold", cpu_hold, 0);
                chk("idle_done", done, 0);
            end else begin
                chk("load_busy", busy, 1);
                chk("load_hold", cpu_hold, 1);
                if (mem_write) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected", mem_address, mem_data);
                    end else begin
                        logic [AW+DW-1:0] e;
                        e = exp_q.pop_front();
                        chk("wr_addr", mem_address, e[DW +: AW]);
                        chk("wr_data", mem_data, e[DW-1:0]);
                    end
                end
            end
            if (!done) chk("aborted_without_done", aborted, 0);
            if (done) begin
                done_seen = 1'b1;
                done_cyc  = cyc;
                done_abt  = aborted;
                m_active  = 1'b0;
            end
        end
    end

    task automatic start_load(input int len);
        @(posedge clk); #1;
        load_req  = 1'b1;
        load_len  = AW'(len);
        req_cyc   = cyc;
        done_seen = 1'b0;
        hold_cnt  = 0;
        wr_cnt    = 0;
        m_ptr     = 0;
        m_nbytes  = 0;
        m_word    = '0;
        @(posedge clk);
        m_active = 1'b1;
        #1;
        load_req = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input bit chk_rdy);
        bit ok = 1'b0;
        bit rdy;
        for (int j = 0; j < gap; j++) begin
            byte_valid = 1'b0;
            @(negedge clk);
            if (chk_rdy && j > 0) chk("ready_while_stalled", byte_ready, 1);
            @(posedge clk); #1;
        end
        byte_valid = 1'b1;
        byte_data  = b;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            rdy = byte_ready;
            @(posedge clk); #1;
            if (rdy) ok = 1'b1;
        end
        byte_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL byte_accept_timeout: byte 0x%0h never accepted", b);
        end else begin
            m_word = (m_word << 8) | DW'(b);
            m_nbytes++;
            if (m_nbytes == WB) begin
                exp_q.push_back({AW'(m_ptr), m_word});
                m_ptr++;
                m_nbytes = 0;
            end
        end
    endtask

    task automatic wait_done(input int bound);
        for (int t = 0; t < bound && !done_seen; t++) @(posedge clk);
        #1;
        if (!done_seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: no done within %0d cycles", bound);
        end
    endtask

    task automatic check_outputs_reset(input string tag, input logic [AW-1:0] fa);
        chk({tag, "_ready"}, byte_ready, 0);
        chk({tag, "_write"}, mem_write, 0);
        chk({tag, "_hold"}, cpu_hold, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_aborted"}, aborted, 0);
        chk({tag, "_data"}, mem_data, 0);
        chk({tag, "_addr"}, mem_address, fa);
    endtask

    initial begin
        // Reset state, with fetch passthrough.
        fetch_address = 12'h123;
        #3;
        check_outputs_reset("rst0", 12'h123);
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            fetch_address = AW'(12'h0F0 + i * 12'h111);
        end

        // Two words, back-to-back bytes.
        start_load(2);
        send_byte(8'h1A, 0, 0);
        send_byte(8'h05, 0, 0);
        send_byte(8'h2B, 0, 0);
        send_byte(8'h07, 0, 0);
        wait_done(40);
        chk("t1_done_latency", done_cyc - req_cyc, 8);
        chk("t1_hold_cycles", hold_cnt, 8);
        chk("t1_writes", wr_cnt, 2);
        chk("t1_aborted", done_abt, 0);
        chk("t1_last_addr", last_wr_addr, 12'h001);
        chk("t1_last_data", last_wr_data, 16'h2B07);
        chk("t1_hold_release", cpu_hold, 0);
        chk("t1_pending", exp_q.size(), 0);

        // Same load with three idle cycles before each byte.
        start_load(2);
        send_byte(8'h1A, 3, 1);
        send_byte(8'h05, 3, 1);
        send_byte(8'h2B, 3, 1);
        send_byte(8'h07, 3, 1);
        wait_done(40);
        chk("t2_writes", wr_cnt, 2);
        chk("t2_aborted", done_abt, 0);
        chk("t2_last_data", last_wr_data, 16'h2B07);
        chk("t2_pending", exp_q.size(), 0);

        // Zero-length load.
        start_load(0);
        wait_done(10);
        chk("t3_done_latency", done_cyc - req_cyc, 2);
        chk("t3_writes", wr_cnt, 0);
        chk("t3_aborted", done_abt, 0);

        // Abort after the third byte of a four-word load.
        start_load(4);
        send_byte(8'h11, 0, 0);
        send_byte(8'h22, 0, 0);
        send_byte(8'h33, 0, 0);
        begin
            int abort_cyc;
            abort = 1'b1;
            abort_cyc = cyc;
            @(posedge clk); #1;
            abort = 1'b0;
            wait_done(10);
            chk("t4_done_after_abort", done_cyc - abort_cyc, 1);
        end
        chk("t4_aborted", done_abt, 1);
        chk("t4_writes", wr_cnt, 1);
        chk("t4_last_data", last_wr_data, 16'h1122);
        chk("t4_hold_release", cpu_hold, 0);
        chk("t4_pending", exp_q.size(), 0);

        // Abort in IDLE is ignored.
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        chk("t5_idle_abort_busy", busy, 0);

        // load_req together with abort in IDLE starts the load.
        @(posedge clk); #1;
        abort = 1'b1;
        start_load(1);
        abort = 1'b0;
        send_byte(8'h5A, 0, 0);
        send_byte(8'hC3, 0, 0);
        wait_done(20);
        chk("t6_aborted", done_abt, 0);
        chk("t6_writes", wr_cnt, 1);
        chk("t6_data", last_wr_data, 16'h5AC3);

        // load_req during RECV is ignored; then a fresh load restarts at 0.
        start_load(2);
        send_byte(8'h1A, 0, 0);
        load_req = 1'b1;
        load_len = AW'(7);
        @(posedge clk); #1;
        load_req = 1'b0;
        send_byte(8'h05, 0, 0);
        send_byte(8'h2B, 0, 0);
        send_byte(8'h07, 0, 0);
        wait_done(40);
        chk("t7_done_latency", done_cyc - req_cyc, 9);
        chk("t7_writes", wr_cnt, 2);
        chk("t7_pending", exp_q.size(), 0);
        start_load(1);
        send_byte(8'hAB, 0, 0);
        send_byte(8'hCD, 0, 0);
        wait_done(20);
        chk("t7_new_latency", done_cyc - req_cyc, 5);
        chk("t7_new_addr", last_wr_addr, 12'h000);
        chk("t7_new_data", last_wr_data, 16'hABCD);

        // Asynchronous reset in the middle of RECV.
        start_load(2);
        send_byte(8'h1A, 0, 0);
        #2;
        fetch_address = 12'h0A3;
        #1;
        reset = 1'b0;
        #1;
        check_outputs_reset("async_rst", 12'h0A3);
        exp_q.delete();
        m_active = 1'b0;
        @(posedge clk); #1;
        check_outputs_reset("async_rst_clk", 12'h0A3);
        reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("post_rst_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Arbitrates the program-code RAM's single address/write port between instruction fetch (program counter) and a byte-serial program download.
- In IDLE it passes the fetch address through transparently.
- On a load request it holds the CPU in reset, assembles incoming bytes into instruction words (opcode nibble + address), and writes them to consecutive program addresses from 0.
- Sits between the program counter, the program RAM and an external byte source (UART receiver or debug port).

Parameters:
- ADDR_WIDTH, 12, program address width; also the width of the word count.
- DATA_WIDTH, 16, instruction word width; must be a multiple of 8.
- WORD_BYTES, DATA_WIDTH/8, bytes per instruction word (derived, not overridden).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- load_req  input  1  start a download; sampled only in IDLE.
- load_len  input  ADDR_WIDTH  number of words to load; sampled with load_req.
- abort  input  1  terminate the download in progress.
- byte_valid  input  1  byte_data is valid.
- byte_data  input  8  download byte.
- byte_ready  output  1  loader accepts a byte this cycle.
- fetch_address  input  ADDR_WIDTH  program counter output.
- mem_address  output  ADDR_WIDTH  program RAM address.
- mem_data  output  DATA_WIDTH  program RAM write data.
- mem_write  output  1  program RAM write strobe.
- cpu_hold  output  1  holds program counter and ICU in reset.
- busy  output  1  state is not IDLE.
- done  output  1  one-cycle pulse at end of a download.
- aborted  output  1  valid with done; 1 if the download was aborted.

Behaviour:
- Reset (async, reset=0):
  - State returns to IDLE; word pointer, byte counter and mem_data clear to 0.
  - byte_ready, mem_write, cpu_hold, busy, done and aborted are 0.
  - mem_address = fetch_address.
  - RAM contents already written are kept.
- States: IDLE, ARM, RECV, WRITE, FINISH.
- IDLE:
  - mem_address = fetch_address (combinational); mem_write = 0.
  - load_req=1 captures load_len into the remaining-word counter and moves to ARM.
- ARM:
  - One cycle with cpu_hold=1, so the CPU is quiesced before any write.
  - Moves to FINISH if the captured length is 0, otherwise to RECV.
- RECV:
  - byte_ready=1. A byte is accepted on byte_valid & byte_ready.
  - Words are big-endian: the first byte is bits [DATA_WIDTH-1:DATA_WIDTH-8].
  - Each accepted byte shifts into the word register and increments the byte counter.
  - After WORD_BYTES bytes, the counter clears and the state moves to WRITE.
  - While byte_valid=0, the loader stalls with no timeout.
- WRITE:
  - One cycle: mem_write=1, mem_address = word pointer, mem_data = assembled word; byte_ready=0.
  - Next: pointer increments and remaining count decrements.
  - Moves to FINISH if remaining was 1, otherwise back to RECV.
- FINISH:
  - One cycle: done=1, cpu_hold=1, then IDLE.
  - cpu_hold deasserts in IDLE, so the CPU restarts from address 0.
- In every non-IDLE state, cpu_hold=1, busy=1 and mem_address = word pointer.
- Timing with back-to-back bytes: N words take 1 + (WORD_BYTES+1)·N + 1 cycles from the load_req cycle+1 to the done cycle.
- Abort:
  - In ARM, RECV or WRITE, abort=1 moves to FINISH next cycle; done=1 and aborted=1 there.
  - A WRITE in the abort cycle still completes.
  - A partial word is discarded.
  - Abort in IDLE or FINISH is ignored.
- Simultaneous events:
  - load_req while busy is ignored (no queuing).
  - load_req and abort together in IDLE: the load starts.
- Length and pointer limits:
  - Maximum load_len is 2^ADDR_WIDTH−1.
  - The pointer does not wrap within a legal load.
- aborted is 0 whenever done is 0.

Decomposition:
- Package loader_pkg:
  - enum loader_state_t {IDLE, ARM, RECV, WRITE, FINISH};
  - constant BYTE_WIDTH = 8.
- Sub-module word_assembler (parameter DATA_WIDTH):
  - Byte shift register plus byte counter, with shift, clear and word_full signals.
- The top FSM owns the pointer, remaining count, port mux and status outputs.

Test Plan:
- Release reset; load_req with load_len=2; bytes 0x1A,0x05,0x2B,0x07 with byte_valid held high → writes 0x1A05@0 and 0x2B07@1; done pulse 8 cycles after load_req; cpu_hold high for exactly those 8 cycles.
- Same load with byte_valid low for 3 cycles between each byte → identical writes; byte_ready high throughout RECV; no mem_write until a word completes.
- load_len=0 → no mem_write; done=1 2 cycles after load_req; aborted=0.
- load_len=4; abort after the 3rd byte → exactly one write (word 0); done=1 with aborted=1 next cycle; cpu_hold low on the following cycle.
- reset=0 asynchronously mid-RECV → all outputs 0 without a clock edge; mem_address tracks fetch_address (drive 0x0A3 → 0x0A3).
- load_req pulsed during RECV with load_len=7 → ignored; the original length completes; a subsequent IDLE load_req starts a new load at address 0.
